// File: rtl/csa_accum_64.sv
// Streaming carry-save accumulator: sums a packet of operands into redundant
// sum/carry vectors and holds them as a/b operands for the downstream adder.
module csa_accum_64 #(
  parameter int W     = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_a,
  output logic [W-1:0]     out_b,
  output logic [CNT_W-1:0] out_cnt
);

  // state | meaning
  // ACC   | accepting operands of the current packet
  // HOLD  | packet complete, vectors presented until out_ready
  typedef enum logic {ACC = 1'b0, HOLD = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     s_q, s_d;
  logic [W-1:0]     c_q, c_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [W-1:0]     csa_sum;
  logic [W-1:0]     csa_maj;

  // One 3:2 compressor row; the carry out of the top bit is dropped by the shift.
  assign csa_sum = s_q ^ c_q ^ in_data;
  assign csa_maj = (s_q & c_q) | (s_q & in_data) | (c_q & in_data);

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    case (state_q)
      ACC: begin
        if (in_valid) begin
          s_d   = csa_sum;
          c_d   = {csa_maj[W-2:0], 1'b0};
          cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
          if (in_last) state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          s_d     = '0;
          c_d     = '0;
          cnt_d   = '0;
          state_d = ACC;
        end
      end
      default: state_d = ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACC;
      s_q     <= '0;
      c_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == ACC);
  assign out_valid = (state_q == HOLD);
  assign out_a     = s_q;
  assign out_b     = c_q;
  assign out_cnt   = cnt_q;

endmodule

// File: tb/tb_csa_accum_64.sv
// Bench for csa_accum_64: directed packet table, corner sequences and a
// randomized run scored against plain modular sums of each packet.
module tb_csa_accum_64;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_a;
  logic [63:0] out_b;
  logic [15:0] out_cnt;

  csa_accum_64 dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_cnt(out_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one operand until it is taken; inputs change only 1 time unit after an edge.
  task automatic send_op(input logic [63:0] d, input logic last);
    logic acc;
    logic done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    for (int k = 0; k < 200 && !done; k++) begin
      acc = in_ready;
      step();
      if (acc) done = 1'b1;
    end
    if (!done) chk("send_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  typedef struct {
    int                n;
    logic [3:0][63:0]  ops;
    logic [63:0]       exp_sum;
    logic [15:0]       exp_cnt;
    bit                b_nonzero;
  } vec_t;

  vec_t tv[4];

  typedef struct {
    logic [63:0] sum;
    logic [15:0] cnt;
  } pkt_t;

  pkt_t exp_q[$];
  int   released;
  int   produced;

  initial begin
    logic [63:0] hold_a, hold_b;
    logic [15:0] hold_c;

    tv[0] = '{1, {64'd0, 64'd0, 64'd0, 64'h1234}, 64'h1234, 16'd1, 1'b0};
    tv[1] = '{3, {64'd0, 64'h1, 64'h1, 64'hFF}, 64'h101, 16'd3, 1'b1};
    tv[2] = '{2, {64'd0, 64'd0, 64'h2, 64'hFFFF_FFFF_FFFF_FFFF}, 64'h1, 16'd2, 1'b1};
    tv[3] = '{4, {64'd4, 64'd3, 64'd2, 64'd1}, 64'd10, 16'd4, 1'b0};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_a", out_a, 64'd0);
    chk("rst_out_b", out_b, 64'd0);
    chk("rst_out_cnt", {48'd0, out_cnt}, 64'd0);

    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < tv[i].n; j++) send_op(tv[i].ops[j], j == tv[i].n - 1);
      chk("tbl_out_valid", {63'd0, out_valid}, 64'd1);
      chk("tbl_sum", out_a + out_b, tv[i].exp_sum);
      chk("tbl_cnt", {48'd0, out_cnt}, {48'd0, tv[i].exp_cnt});
      if (tv[i].n == 1) begin
        chk("tbl_single_a", out_a, tv[i].ops[0]);
        chk("tbl_single_b", out_b, 64'd0);
      end
      if (tv[i].b_nonzero) chk("tbl_b_nonzero", {63'd0, out_b != 64'd0}, 64'd1);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("tbl_release_ready", {63'd0, in_ready}, 64'd1);
      chk("tbl_release_valid", {63'd0, out_valid}, 64'd0);
    end

    // Backpressure: operands offered during HOLD must not be absorbed.
    send_op(64'd100, 1'b0);
    send_op(64'd23, 1'b1);
    hold_a = out_a; hold_b = out_b; hold_c = out_cnt;
    chk("bp_sum", out_a + out_b, 64'd123);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_last  = 1'b1;
      in_data  = 64'h5000 + 64'(k);
      chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
      step();
      chk("bp_a_stable", out_a, hold_a);
      chk("bp_b_stable", out_b, hold_b);
      chk("bp_cnt_stable", {48'd0, out_cnt}, {48'd0, hold_c});
    end
    in_data   = 64'h77;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp_after_release_cnt", {48'd0, out_cnt}, 64'd0);
    chk("bp_after_release_ready", {63'd0, in_ready}, 64'd1);
    step();
    in_valid = 1'b0; in_last = 1'b0;
    chk("bp_next_valid", {63'd0, out_valid}, 64'd1);
    chk("bp_next_sum", out_a + out_b, 64'h77);
    chk("bp_next_cnt", {48'd0, out_cnt}, 64'd1);
    out_ready = 1'b1; step(); out_ready = 1'b0;

    // Reset mid-packet, then a fresh packet, then reset while holding.
    send_op(64'd11, 1'b0);
    send_op(64'd22, 1'b0);
    send_op(64'd33, 1'b0);
    rst = 1'b1; step(); rst = 1'b0;
    chk("midrst_cnt", {48'd0, out_cnt}, 64'd0);
    chk("midrst_sum", out_a + out_b, 64'd0);
    send_op(64'd7, 1'b0);
    send_op(64'd9, 1'b1);
    chk("midrst_pkt_sum", out_a + out_b, 64'd16);
    chk("midrst_pkt_cnt", {48'd0, out_cnt}, 64'd2);
    chk("holdrst_pre_valid", {63'd0, out_valid}, 64'd1);
    rst = 1'b1; step(); rst = 1'b0;
    chk("holdrst_valid", {63'd0, out_valid}, 64'd0);
    chk("holdrst_ready", {63'd0, in_ready}, 64'd1);

    // Random packets with stalls on both sides.
    released = 0;
    produced = 0;
    fork
      begin
        for (int p = 0; p < 1000; p++) begin
          int          len;
          logic [63:0] sum;
          logic [63:0] d;
          pkt_t        e;
          len = $urandom_range(1, 40);
          sum = '0;
          for (int j = 0; j < len; j++) begin
            while ($urandom_range(0, 4) == 0) begin
              in_valid = 1'b0;
              in_data  = {$urandom, $urandom};
              in_last  = $urandom_range(0, 1) == 1;
              step();
            end
            d   = {$urandom, $urandom};
            sum = sum + d;
            if (j == len - 1) begin
              e.sum = sum;
              e.cnt = 16'(len);
              exp_q.push_back(e);
              produced++;
            end
            send_op(d, j == len - 1);
          end
        end
      end
      begin
        int cyc;
        cyc = 0;
        while (released < 1000 && cyc < 90000) begin
          if (out_valid) begin
            out_ready = $urandom_range(0, 3) != 0;
            if (out_ready) begin
              if (exp_q.size() == 0) begin
                chk("rnd_unexpected_pkt", 64'd1, 64'd0);
              end else begin
                pkt_t e;
                e = exp_q.pop_front();
                chk("rnd_sum", out_a + out_b, e.sum);
                chk("rnd_cnt", {48'd0, out_cnt}, {48'd0, e.cnt});
              end
              released++;
            end
          end else begin
            out_ready = $urandom_range(0, 1) == 1;
          end
          step();
          cyc++;
        end
        out_ready = 1'b0;
      end
    join
    chk("rnd_released", 64'(released), 64'd1000);
    chk("rnd_produced", 64'(produced), 64'd1000);
    chk("rnd_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/csa_accum_64.md
# csa_accum_64

Streaming carry-save accumulator that sums a packet of W-bit operands, one per cycle, into redundant sum/carry vectors using a row of 3:2 compressors with no carry propagation. It sits directly upstream of the 64-bit registered carry-propagate adder. At end of packet it presents the two vectors as that adder's a/b operands, with its cin tied to 0. The final resolved sum is a + b mod 2^W; the adder's cout carries no meaning for this block and is ignored downstream.

## Interface
- W, 64, operand and vector width
- CNT_W, 16, width of the operand counter
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset rst, synchronous, active-high
- in_valid  in  1  operand present
- in_ready  out  1  block can accept an operand this cycle
- in_data  in  W  operand, unsigned, summed mod 2^W
- in_last  in  1  qualifies in_data as final operand of the packet
- out_valid  out  1  out_a/out_b/out_cnt hold a completed packet
- out_ready  in  1  downstream accepts the packet
- out_a  out  W  redundant sum vector S
- out_b  out  W  redundant carry vector C
- out_cnt  out  CNT_W  operands in the packet, saturating at 2^CNT_W-1

## Operation
- Registers: S[W-1:0], C[W-1:0], cnt[CNT_W-1:0], state in {ACC, HOLD}.
- Reset: state=ACC, S=0, C=0, cnt=0, out_valid=0, in_ready=1 the cycle after rst is sampled high. out_a, out_b, and out_cnt read 0.
- in_ready = (state==ACC). out_valid = (state==HOLD). out_a=S, out_b=C, out_cnt=cnt, all driven directly from registers.
- Accept: in_valid && in_ready. On accept:
  - S <= S ^ C ^ x
  - C <= ((S&C)|(S&x)|(C&x)) << 1, truncated to W bits; bit 0 is 0 and the carry out of bit W-1 is discarded
  - cnt <= cnt+1, saturating
- Invariant: (S + C) mod 2^W = sum of accepted operands of the current packet mod 2^W.
- Accept with in_last=1: state -> HOLD after the register update above.
- HOLD: S, C, and cnt are frozen; in_data is ignored because in_ready=0.
- Release: out_valid && out_ready. At release, S=0, C=0, cnt=0, state -> ACC. There is no same-cycle accept of the next packet's first operand.
- in_last is only meaningful when accepted; it is ignored when in_valid=0.
- Empty packets do not exist. A packet contains at least one operand.
- rst mid-packet or in HOLD discards all state immediately. A pending output is lost; out_valid drops the next cycle.
- in_valid must not depend on in_ready. out_ready may be held high permanently.

## Timing
- Latency: last operand accepted at edge N -> out_valid=1 after edge N, i.e. visible in cycle N+1.
- Throughput: one operand per cycle within a packet.
- Minimum cost per packet boundary: one cycle with in_ready=0 (HOLD with out_ready=1).
- Back-to-back packets of k operands with out_ready=1 take k+1 cycles each.
- Output stable: out_a, out_b, and out_cnt do not change while out_valid=1 and out_ready=0.
- Downstream adder adds one further registered cycle. Resolved sum appears 2 cycles after out_valid is first sampled with out_ready=1 (input register plus output register of the adder).
- Critical path: one 3:2 compressor level plus a 2-input mux. The path is independent of W.

## Test plan
- Single-operand packet: rst, then one in_data=0x0000_0000_0000_1234 with in_last=1 -> next cycle out_valid=1, out_a=0x1234, out_b=0, out_cnt=1. Release -> in_ready=1 the following cycle.
- Carry generation: operands 0xFF, 0x01, 0x01 (last) -> out_a+out_b mod 2^64 = 0x101 and out_cnt=3; out_b nonzero.
- Wrap-around: operands 0xFFFF_FFFF_FFFF_FFFF and 0x2 (last) -> (out_a+out_b) mod 2^64 = 0x1. Through the downstream adder, sum_r=0x1.
- Backpressure: complete a packet with out_ready=0 for 5 cycles and in_valid=1 with changing in_data -> in_ready=0, out_* unchanged all 5 cycles, no operand absorbed. out_ready=1 -> release; the next operand is accepted one cycle later.
- Reset mid-operation: rst asserted after 3 of 5 operands, then a fresh 2-operand packet of 7 and 9 -> out_a+out_b=16, out_cnt=2. rst asserted in HOLD -> out_valid=0 the next cycle.
- Random: 1000 packets of 1-40 random 64-bit operands with random in_valid/out_ready stalls -> each out_a+out_b mod 2^64 matches the scoreboard sum, out_cnt matches the packet length, and no packet is lost or duplicated.
